// File: rtl/fifo_pkg.sv
// Shared constants and types for the parameterised FIFO.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_AF_LEVEL   = 6;
    localparam int DEF_AE_LEVEL   = 2;

    // Accepted-operation encoding: {write accepted, read accepted}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Number of words held by a FIFO with the given pointer width
    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Bus bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface param_fifo_if #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
) ();

    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr;
    logic                  rd;
    logic                  clear_err;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   fifo_counter;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in, wr, rd, clear_err,
        input  data_out, valid_out, fifo_counter, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  data_in, wr, rd, clear_err,
        output data_out, valid_out, fifo_counter, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read port.
// Only the read register is reset; the array itself keeps its contents.
module fifo_mem #(
    parameter int DATA_WIDTH = fifo_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_pkg::depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Write port: store the word when the controller accepts a write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word (old contents on a same-address write)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: pointers, occupancy counter, status and
// sticky error flags. Storage lives in fifo_mem.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic        clk,
    input  logic        reset,
    param_fifo_if.slave bus
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth_of(ADDR_WIDTH));
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  valid_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    fifo_op_e              op_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic                  overflow_nxt_s;
    logic                  underflow_nxt_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Status decode and acceptance; reset suppresses any request in its cycle
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        full_s    = (count_r == DEPTH_C);
        // A full FIFO still takes a write when a read frees a slot on the same edge
        wr_acc_s  = bus.wr & (~full_s | bus.rd) & ~reset;
        // No fall-through: an empty FIFO never serves a read, even with a write
        rd_acc_s  = bus.rd & ~empty_s & ~reset;
        op_s      = fifo_op_e'({wr_acc_s, rd_acc_s});
        ovf_set_s = bus.wr & ~bus.rd & full_s;
        unf_set_s = bus.rd & empty_s;
    end

    // Next occupancy from the accepted operation pair
    always_comb begin
        count_nxt_s = count_r;
        case (op_s)
            OP_WRITE: count_nxt_s = count_r + ONE_C;
            OP_READ:  count_nxt_s = count_r - ONE_C;
            OP_BOTH:  count_nxt_s = count_r;
            OP_IDLE:  count_nxt_s = count_r;
            default:  count_nxt_s = count_r;
        endcase
    end

    // Sticky error next state: a new error outranks a clear in the same cycle
    always_comb begin
        if (ovf_set_s) begin
            overflow_nxt_s = 1'b1;
        end else if (bus.clear_err) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
        if (unf_set_s) begin
            underflow_nxt_s = 1'b1;
        end else if (bus.clear_err) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // Pointer, counter, read-valid and error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r    <= {ADDR_WIDTH{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            // Pointers roll over naturally at ADDR_WIDTH bits
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end
            count_r     <= count_nxt_s;
            valid_r     <= rd_acc_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_r),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    assign bus.data_out     = rd_data_s;
    assign bus.valid_out    = valid_r;
    assign bus.fifo_counter = count_r;
    assign bus.empty        = empty_s;
    assign bus.full         = full_s;
    assign bus.almost_empty = (count_r <= AE_C);
    assign bus.almost_full  = (count_r >= AF_C);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, pointer width; DEPTH = 2**ADDR_WIDTH (8 by default).
REQ-003 SHALL have parameter AF_LEVEL, default 6, almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-2).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port rd  input  1  read request.
REQ-010 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port valid_out  output  1  data_out updated this cycle.
REQ-013 SHALL have port fifo_counter  output  ADDR_WIDTH+1  words stored (0..DEPTH).
REQ-014 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  status.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted when wr=1 and (full=0 or rd=1); accepted write stores data_in at wr_pointer, then wr_pointer+1.
REQ-017 Read accepted when rd=1 and empty=0; data_out <= word at rd_pointer on that edge, rd_pointer+1, valid_out=1 for that one cycle (latency 1).
REQ-018 Without an accepted read, data_out SHALL hold its value and valid_out SHALL be 0.
REQ-019 Pointers SHALL wrap modulo DEPTH with no extra logic beyond ADDR_WIDTH-bit rollover.
REQ-020 fifo_counter: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 Full and wr=rd=1: both accepted, counter stays DEPTH, no overflow.
REQ-022 Empty and wr=rd=1: write accepted, read rejected (no fall-through), counter becomes 1, underflow set.
REQ-023 empty = (counter==0); full = (counter==DEPTH); almost_full = (counter>=AF_LEVEL); almost_empty = (counter<=AE_LEVEL); all combinational from counter.
REQ-024 overflow SHALL set on wr=1, rd=0, full=1; write dropped, memory and pointers unchanged.
REQ-025 underflow SHALL set on rd=1, empty=1; data_out unchanged, valid_out=0.
REQ-026 overflow/underflow SHALL stay set until clear_err=1 or reset; a new error in the clearing cycle wins (flag stays 1).

Reset
REQ-027 reset=1 at a clock edge SHALL zero wr_pointer, rd_pointer, fifo_counter, data_out, valid_out, overflow, underflow; wr/rd in that cycle ignored.
REQ-028 After reset: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Memory contents SHALL NOT be reset; reset mid-operation discards stored words logically.

Structure
REQ-030 Package fifo_pkg SHALL hold default DATA_WIDTH, ADDR_WIDTH, AF_LEVEL, AE_LEVEL constants.
REQ-031 Storage SHALL be sub-module fifo_mem: simple dual-port array, synchronous write, registered read port.
REQ-032 Control (pointers, counter, flags, errors) SHALL reside in param_fifo.

Verification
REQ-033 Reset, write 0x11..0x88 (8 words) -> full=1, counter=8, almost_full from 6th write; read 8 -> data_out 0x11..0x88 in order, one cycle after each rd, empty=1.
REQ-034 Full, wr=1 rd=0 data 0xDEAD -> overflow=1, counter=8; draining yields no 0xDEAD; clear_err -> overflow=0.
REQ-035 Empty, wr=rd=1 data 0xA5 -> counter=1, underflow=1, valid_out=0; next rd -> data_out=0xA5.
REQ-036 Full, wr=rd=1 for 20 cycles with incrementing data -> counter=8 throughout, outputs strictly in order across pointer wrap.
REQ-037 Counter=5, reset=1 with wr=1 -> next cycle counter=0, empty=1, data_out=0, errors=0.
REQ-038 DATA_WIDTH=8, ADDR_WIDTH=4 instance: 16 writes -> full at 16, almost_full at 6, ordered readback.
